toll_lane_arbiter: RTL and testbench
====================================

// Module: toll_lane_arbiter
// PURPOSE
//   Shares one toll_controller event port between NUM_LANES lane UART receivers.
//   Round-robin selects one pending lane event at a time.
//   Presents the event with a lane tag on a valid/ready link.
//   Enforces GAP_CYCLES idle cycles after each transfer so the shared controller can settle.
// PARAMETERS
//   NUM_LANES   4   number of requesting lanes (2..8)
//   CODE_W      3   event code width; matches uart_data
//   GAP_CYCLES  2   idle cycles after each accepted transfer (0 = none)
//   CNT_W       16  width of xfer_count
// PORTS
//   clk         in   1                  single clock; all logic on posedge
//   reset       in   1                  synchronous, active-high
//   lane_valid  in   NUM_LANES          lane i has an event pending
//   lane_code   in   NUM_LANES*CODE_W   lane i code in bits [i*CODE_W +: CODE_W]
//   lane_ready  out  NUM_LANES          one-hot, 1-cycle pulse; lane's event was captured
//   out_valid   out  1                  event presented to toll_controller
//   out_code    out  CODE_W             captured event code
//   out_lane    out  clog2(NUM_LANES)   index of the source lane
//   out_ready   in   1                  toll_controller accepts the event
//   busy        out  1                  FSM not in IDLE
//   xfer_count  out  CNT_W              completed transfers; wraps to 0 after all-ones
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, rr_ptr=0, gap_cnt=0, xfer_count=0.
//     Also out_valid=0, out_code=0, out_lane=0, lane_ready=0, busy=0.
//     Reset mid-transfer drops the held event; no lane_ready is re-issued.
//   IDLE:
//     Search for a lane with lane_valid=1, starting at rr_ptr, ascending, wrapping at NUM_LANES.
//     Winner k: lane_ready[k]=1 (combinational, this cycle only).
//       Register out_code=lane_code[k], out_lane=k, then go to GRANT.
//     No lane_valid: stay in IDLE, lane_ready=0.
//   GRANT:
//     out_valid=1. out_code and out_lane stay stable until the handshake.
//     out_valid & out_ready: xfer_count++, rr_ptr=(k+1) mod NUM_LANES.
//       Next state is GAP if GAP_CYCLES>0, else IDLE.
//     out_ready=0: hold indefinitely. No timeout. Other lanes wait.
//   GAP:
//     out_valid=0. Counts GAP_CYCLES cycles, then goes to IDLE. lane_valid is ignored here.
//   Latency:
//     lane_valid at cycle t, FSM in IDLE -> lane_ready at t, out_valid at t+1.
//     Minimum spacing between transfers with out_ready tied high: 2+GAP_CYCLES cycles.
//   Rules:
//     - lane_valid is sampled only in IDLE. Withdrawing it before selection is legal; nothing captured.
//     - lane_ready never asserts outside IDLE and is never multi-hot.
//     - out_ready while out_valid=0 has no effect.
//     - All lanes valid continuously: grant order is 0,1,2,3,0,... (NUM_LANES=4).
//     - rr_ptr wraps from NUM_LANES-1 to 0.
// CONFIGURATION
//   EMERGENCY_PRIO_EN defined:
//     In IDLE, any valid lane with lane_code==all-ones (emergency vehicle) wins over round-robin.
//     Several emergency lanes: lowest index wins.
//     rr_ptr is NOT updated after an emergency transfer.
//   EMERGENCY_PRIO_EN undefined:
//     All-ones is an ordinary code under pure round-robin.
// TESTING
//   1 Reset then idle: all lane_valid=0 for 20 cycles -> out_valid=0, busy=0, lane_ready=0, xfer_count=0.
//   2 Single lane: lane 2 valid with code 3'b101, out_ready=1 ->
//       lane_ready=4'b0100 one cycle, next cycle out_valid=1, out_code=5, out_lane=2.
//       xfer_count=1. Then 2 GAP cycles with out_valid=0.
//   3 Fairness: all 4 lanes valid constantly, out_ready=1 ->
//       out_lane sequence 0,1,2,3,0,1. Transfers spaced 4 cycles apart.
//   4 Backpressure: lane 1 code 3'b011, out_ready=0 for 10 cycles then 1 ->
//       out_valid/out_code/out_lane stable all 10 cycles, one transfer, xfer_count+1.
//   5 Reset mid-GRANT: assert reset while out_valid=1 ->
//       next cycle out_valid=0, state IDLE, rr_ptr=0, xfer_count=0.
//   6 EMERGENCY_PRIO_EN: rr_ptr=0, lane 0 code 3'b001, lane 3 code 3'b111, both valid ->
//       lane 3 granted first, then lane 0. Without the macro: lane 0 first, then lane 3.

Source files
------------

// File: rtl/toll_lane_arbiter.sv
// rtl/toll_lane_arbiter.sv - round-robin arbiter sharing one toll_controller event port across lane receivers
// Optional EMERGENCY_PRIO_EN: valid lanes carrying an all-ones code pre-empt round-robin, lowest index first.
module toll_lane_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int CODE_W     = 3,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         lane_valid,
  input  logic [NUM_LANES*CODE_W-1:0]  lane_code,
  output logic [NUM_LANES-1:0]         lane_ready,
  output logic                         out_valid,
  output logic [CODE_W-1:0]            out_code,
  output logic [$clog2(NUM_LANES)-1:0] out_lane,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [CNT_W-1:0]             xfer_count
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LANE_W-1:0] rr_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              grant_emerg;
  logic              win_found;
  logic              win_emerg;
  logic [LANE_W-1:0] win_lane;
  logic              handshake;
  logic              gap_done;

  // Lane index base+off, wrapped at NUM_LANES (which need not be a power of two).
  function automatic logic [LANE_W-1:0] lane_wrap(input logic [LANE_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_LANES) sum = sum - NUM_LANES;
    return LANE_W'(sum);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_lane  = '0;
    win_emerg = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!win_found && lane_valid[lane_wrap(rr_ptr, i)]) begin
        win_found = 1'b1;
        win_lane  = lane_wrap(rr_ptr, i);
      end
    end
`ifdef EMERGENCY_PRIO_EN
    // Descending scan so the lowest-index emergency lane is the last to overwrite.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_valid[i] && (lane_code[i*CODE_W +: CODE_W] == {CODE_W{1'b1}})) begin
        win_found = 1'b1;
        win_lane  = LANE_W'(i);
        win_emerg = 1'b1;
      end
    end
`endif
  end

  assign handshake = (state == S_GRANT) && out_ready;
  assign gap_done  = (int'(gap_cnt) >= GAP_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_GRANT;
      S_GRANT: if (out_ready) state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lane_ready = '0;
    if ((state == S_IDLE) && win_found && !reset) lane_ready[win_lane] = 1'b1;
    out_valid = (state == S_GRANT);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      xfer_count  <= '0;
      out_code    <= '0;
      out_lane    <= '0;
      grant_emerg <= 1'b0;
    end else begin
      if ((state == S_IDLE) && win_found) begin
        out_code    <= lane_code[win_lane*CODE_W +: CODE_W];
        out_lane    <= win_lane;
        grant_emerg <= win_emerg;
      end
      if (handshake) begin
        xfer_count <= xfer_count + 1'b1;
        gap_cnt    <= '0;
        // Emergency grants leave the round-robin position untouched.
        if (!grant_emerg) rr_ptr <= lane_wrap(out_lane, 1);
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_toll_lane_arbiter.sv
// tb/tb_toll_lane_arbiter.sv - self-checking bench for toll_lane_arbiter
module tb_toll_lane_arbiter;
  localparam int NL  = 4;
  localparam int CW  = 3;
  localparam int GAP = 2;
  localparam int XW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] lane_valid;
  logic [NL*CW-1:0] lane_code;
  logic [NL-1:0] lane_ready;
  logic          out_valid;
  logic [CW-1:0] out_code;
  logic [1:0]    out_lane;
  logic          out_ready;
  logic          busy;
  logic [XW-1:0] xfer_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] codes [NL];

  toll_lane_arbiter #(.NUM_LANES(NL), .CODE_W(CW), .GAP_CYCLES(GAP), .CNT_W(XW)) dut (
    .clk(clk), .reset(reset), .lane_valid(lane_valid), .lane_code(lane_code),
    .lane_ready(lane_ready), .out_valid(out_valid), .out_code(out_code), .out_lane(out_lane),
    .out_ready(out_ready), .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic pack_codes();
    lane_code = {codes[3], codes[2], codes[1], codes[0]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; lane_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < NL; i++) codes[i] = '0;
    pack_codes();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Spec-level choice: emergency lane (lowest index) if enabled, else first valid from ptr upward mod NL.
  function automatic int model_pick(input logic [NL-1:0] v, input int ptr, output bit emerg);
    emerg = 1'b0;
`ifdef EMERGENCY_PRIO_EN
    for (int i = 0; i < NL; i++)
      if (v[i] && codes[i] == {CW{1'b1}}) begin emerg = 1'b1; return i; end
`endif
    for (int k = 0; k < NL; k++)
      if (v[(ptr + k) % NL]) return (ptr + k) % NL;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    reset = 1'b1; lane_valid = '1;
    #1;
    n_checks++; if (lane_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_lane_ready: got %b exp 0000", lane_ready); end
    @(negedge clk);
    reset = 1'b0; lane_valid = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_out_valid: got %b exp 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b exp 0", busy); end
      n_checks++; if (lane_ready !== 4'b0000) begin n_errors++; $display("FAIL idle_lane_ready: got %b exp 0000", lane_ready); end
      n_checks++; if (xfer_count !== 16'd0) begin n_errors++; $display("FAIL idle_xfer_count: got %0d exp 0", xfer_count); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    codes[2] = 3'b101; pack_codes();
    lane_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_checks++; if (lane_ready !== 4'b0100) begin n_errors++; $display("FAIL single_lane_ready: got %b exp 0100", lane_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_pre_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    lane_valid = 4'b0001;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid: got %b exp 1", out_valid); end
    n_checks++; if (out_code !== 3'd5) begin n_errors++; $display("FAIL single_out_code: got %0d exp 5", out_code); end
    n_checks++; if (out_lane !== 2'd2) begin n_errors++; $display("FAIL single_out_lane: got %0d exp 2", out_lane); end
    n_checks++; if (lane_ready !== 4'b0000) begin n_errors++; $display("FAIL single_grant_ready: got %b exp 0000", lane_ready); end
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_gap_valid: got %b exp 0", out_valid); end
      n_checks++; if (lane_ready !== 4'b0000) begin n_errors++; $display("FAIL single_gap_ready: got %b exp 0000", lane_ready); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_gap_busy: got %b exp 1", busy); end
      n_checks++; if (xfer_count !== 16'd1) begin n_errors++; $display("FAIL single_xfer_count: got %0d exp 1", xfer_count); end
    end
    @(negedge clk); #1;
    // rr_ptr is now 3, so the waiting lane 0 is reached by wrapping.
    n_checks++; if (lane_ready !== 4'b0001) begin n_errors++; $display("FAIL single_wrap_ready: got %b exp 0001", lane_ready); end
  endtask

  task automatic test_fairness();
    int lanes[$];
    int cycs[$];
    int exp_l;
    do_reset();
    for (int i = 0; i < NL; i++) codes[i] = CW'(i + 1);
    pack_codes();
    lane_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 80 && lanes.size() < 6; c++) begin
      #1;
      if (out_valid) begin lanes.push_back(int'(out_lane)); cycs.push_back(c); end
      @(negedge clk);
    end
    n_checks++; if (lanes.size() != 6) begin n_errors++; $display("FAIL fair_count: got %0d exp 6", lanes.size()); end
    for (int k = 0; k < lanes.size(); k++) begin
      exp_l = k % NL;
      n_checks++; if (lanes[k] != exp_l) begin n_errors++; $display("FAIL fair_order[%0d]: got %0d exp %0d", k, lanes[k], exp_l); end
      if (k > 0) begin
        n_checks++; if (cycs[k] - cycs[k-1] != 2 + GAP) begin n_errors++; $display("FAIL fair_spacing[%0d]: got %0d exp %0d", k, cycs[k] - cycs[k-1], 2 + GAP); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    codes[1] = 3'b011; pack_codes();
    lane_valid = 4'b0010; out_ready = 1'b0;
    #1;
    n_checks++; if (lane_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_lane_ready: got %b exp 0010", lane_ready); end
    @(negedge clk);
    lane_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_code !== 3'd3 || out_lane !== 2'd1) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got v=%b code=%0d lane=%0d exp v=1 code=3 lane=1", c, out_valid, out_code, out_lane);
      end
      n_checks++; if (lane_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_other_wait: got %b exp 0000", lane_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_release_valid: got %b exp 1", out_valid); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_after_valid: got %b exp 0", out_valid); end
    n_checks++; if (xfer_count !== 16'd1) begin n_errors++; $display("FAIL bp_xfer_count: got %0d exp 1", xfer_count); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    codes[1] = 3'd2; codes[3] = 3'd6; pack_codes();
    lane_valid = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    lane_valid = '0;
    repeat (1 + GAP) @(negedge clk);
    lane_valid = 4'b1000; out_ready = 1'b0;
    #1;
    n_checks++; if (lane_ready !== 4'b1000) begin n_errors++; $display("FAIL rmg_pre_ready: got %b exp 1000", lane_ready); end
    @(negedge clk);
    lane_valid = '0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || xfer_count !== 16'd1) begin
      n_errors++; $display("FAIL rmg_pre_state: got v=%b cnt=%0d exp v=1 cnt=1", out_valid, xfer_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lane_valid = '1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmg_out_valid: got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmg_busy: got %b exp 0", busy); end
    n_checks++; if (xfer_count !== 16'd0) begin n_errors++; $display("FAIL rmg_xfer_count: got %0d exp 0", xfer_count); end
    n_checks++; if (lane_ready !== 4'b0001) begin n_errors++; $display("FAIL rmg_rr_ptr: got %b exp 0001", lane_ready); end
  endtask

  task automatic test_emergency();
    logic [NL-1:0] pend;
    int got[$];
    int exp_first;
    int exp_second;
    do_reset();
    codes[0] = 3'b001; codes[3] = 3'b111; pack_codes();
    pend = 4'b1001; out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 2; c++) begin
      lane_valid = pend;
      #1;
      if (out_valid) got.push_back(int'(out_lane));
      pend = pend & ~lane_ready;
      @(negedge clk);
    end
`ifdef EMERGENCY_PRIO_EN
    exp_first = 3; exp_second = 0;
`else
    exp_first = 0; exp_second = 3;
`endif
    n_checks++; if (got.size() != 2) begin n_errors++; $display("FAIL emerg_count: got %0d exp 2", got.size()); end
    else begin
      n_checks++; if (got[0] != exp_first) begin n_errors++; $display("FAIL emerg_first: got %0d exp %0d", got[0], exp_first); end
      n_checks++; if (got[1] != exp_second) begin n_errors++; $display("FAIL emerg_second: got %0d exp %0d", got[1], exp_second); end
    end
    lane_valid = '0;
  endtask

  task automatic test_random();
    logic [NL-1:0] pend;
    logic [NL-1:0] exp_ready;
    int  m_ptr, m_lane, m_gap, m_count, w;
    bit  m_held, m_emerg, w_emerg;
    logic [CW-1:0] m_code;
    do_reset();
    pend = '0; m_ptr = 0; m_held = 0; m_gap = 0; m_count = 0; m_lane = 0; m_code = '0; m_emerg = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; codes[i] = CW'($urandom_range(0, 7));
        end else if (pend[i] && $urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      pack_codes();
      lane_valid = pend;
      out_ready  = ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = '0; w = -1; w_emerg = 0;
      if (!m_held && m_gap == 0) begin
        w = model_pick(pend, m_ptr, w_emerg);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      n_checks++; if (lane_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_lane_ready@%0d: got %b exp %b", c, lane_ready, exp_ready); end
      n_checks++; if (out_valid !== m_held) begin n_errors++; $display("FAIL rnd_out_valid@%0d: got %b exp %b", c, out_valid, m_held); end
      n_checks++; if (busy !== (m_held || m_gap > 0)) begin n_errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, busy, m_held || m_gap > 0); end
      n_checks++; if (xfer_count !== XW'(m_count)) begin n_errors++; $display("FAIL rnd_xfer_count@%0d: got %0d exp %0d", c, xfer_count, m_count); end
      if (m_held) begin
        n_checks++; if (out_code !== m_code || int'(out_lane) != m_lane) begin
          n_errors++; $display("FAIL rnd_payload@%0d: got code=%0d lane=%0d exp code=%0d lane=%0d", c, out_code, out_lane, m_code, m_lane);
        end
      end
      if (m_held) begin
        if (out_ready) begin
          m_count++; m_held = 0; m_gap = GAP;
          if (!m_emerg) m_ptr = (m_lane + 1) % NL;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (w >= 0) begin
        m_held = 1; m_lane = w; m_code = codes[w]; m_emerg = w_emerg; pend[w] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; lane_valid = '0; lane_code = '0; out_ready = 1'b0;
    test_reset();
    test_single_lane();
    test_fairness();
    test_backpressure();
    test_reset_mid_grant();
    test_emergency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
